// File: rtl/mccomp_dbg_pkg.sv
// Shared definitions for the CPU debug register dump path:
// FSM state encoding, frame geometry and the frame packing helper.
package mccomp_dbg_pkg;

  localparam int BYTES_PER_REG = 5;
  localparam int NUM_REGS      = 32;
  localparam int FRAME_W       = 8 * BYTES_PER_REG;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SEND,
    FINISH
  } dump_state_t;

  // Index byte first so the host can resynchronise on any register boundary.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [4:0]  idx,
                                                    input logic [31:0] data);
    return {3'b000, idx, data};
  endfunction

endpackage

// File: rtl/reg_dump_shifter.sv
// 40-bit frame register emitted MSB byte first; tracks how many bytes
// have left so the scanner knows when the current register is finished.
module reg_dump_shifter
  import mccomp_dbg_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               clear,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               shift,
  output logic [7:0]         byte_out,
  output logic               last_byte
);

  logic [FRAME_W-1:0] frame;
  logic [2:0]         byte_cnt;

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      frame    <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      frame    <= frame_in;
      byte_cnt <= '0;
    end else if (shift) begin
      frame    <= {frame[FRAME_W-9:0], 8'h00};
      byte_cnt <= byte_cnt + 3'd1;
    end
  end

  assign byte_out  = frame[FRAME_W-1 -: 8];
  assign last_byte = (byte_cnt == 3'(BYTES_PER_REG - 1));

endmodule

// File: rtl/reg_dump_scanner.sv
// Walks the CPU debug read port from FIRST_REG to LAST_REG and streams each
// register as a 5-byte frame over a valid/ready byte interface.
module reg_dump_scanner
  import mccomp_dbg_pkg::*;
#(
  parameter int FIRST_REG     = 0,
  parameter int LAST_REG      = 31,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  Reg_Sel,
  input  logic [31:0] Reg_Data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX   = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX    = 5'((LAST_REG < NUM_REGS) ? LAST_REG : NUM_REGS - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  dump_state_t state, next_state;
  logic [4:0]  reg_idx;
  logic [3:0]  settle_cnt;
  logic        valid_q;
  logic        load_frame;
  logic        transfer;
  logic        kill;
  logic        last_byte;
  logic [7:0]  shifter_byte;

  assign kill     = abort && (state != IDLE);
  assign transfer = valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_frame = 1'b0;
    case (state)
      IDLE:   if (start) next_state = SELECT;
      SELECT: if (settle_cnt == 4'd1) begin
                next_state = SEND;
                load_frame = 1'b1;
              end
      SEND:   if (transfer && last_byte)
                next_state = (reg_idx == LAST_IDX) ? FINISH : SELECT;
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (kill) begin
      next_state = IDLE;
      load_frame = 1'b0;
    end
  end

  // The first SEND cycle only presents the freshly loaded frame; valid rises
  // after it and then stays up until the fifth byte of the register is taken.
  always_ff @(posedge clk) begin
    if (!rstn || kill) begin
      reg_idx    <= '0;
      settle_cnt <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
                reg_idx    <= FIRST_IDX;
                settle_cnt <= SETTLE_LOAD;
              end
        SELECT: settle_cnt <= settle_cnt - 4'd1;
        SEND: if (!valid_q) begin
                valid_q <= 1'b1;
              end else if (out_ready && last_byte) begin
                valid_q <= 1'b0;
                if (reg_idx == LAST_IDX) begin
                  reg_idx <= '0;
                end else begin
                  reg_idx    <= reg_idx + 5'd1;
                  settle_cnt <= SETTLE_LOAD;
                end
              end
        default: reg_idx <= '0;
      endcase
    end
  end

  reg_dump_shifter u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (kill),
    .load      (load_frame),
    .frame_in  (make_frame(reg_idx, Reg_Data)),
    .shift     (transfer),
    .byte_out  (shifter_byte),
    .last_byte (last_byte)
  );

  assign Reg_Sel   = reg_idx;
  assign out_data  = shifter_byte;
  assign out_valid = valid_q;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Directed bench: a cycle table for a single-register, 3-cycle-settle scanner
// plus hand sequences for full dumps, backpressure, abort and mid-dump reset.
module tb_reg_dump_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rstn, a_start, a_abort, a_ready;
  logic [4:0]  a_sel;
  logic [31:0] a_data;
  logic [7:0]  a_out;
  logic        a_valid, a_busy, a_done;

  logic        b_rstn, b_start, b_abort, b_ready;
  logic [4:0]  b_sel;
  logic [31:0] b_data;
  logic [7:0]  b_out;
  logic        b_valid, b_busy, b_done;

  assign a_data = 32'h1000_0000 + {27'd0, a_sel};
  assign b_data = (b_sel == 5'd7) ? 32'hDEAD_BEEF : 32'h0000_0000;

  reg_dump_scanner dut_a (
    .clk(clk), .rstn(a_rstn), .start(a_start), .abort(a_abort),
    .Reg_Sel(a_sel), .Reg_Data(a_data), .out_data(a_out), .out_valid(a_valid),
    .out_ready(a_ready), .busy(a_busy), .done(a_done)
  );

  reg_dump_scanner #(.FIRST_REG(7), .LAST_REG(7), .SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rstn(b_rstn), .start(b_start), .abort(b_abort),
    .Reg_Sel(b_sel), .Reg_Data(b_data), .out_data(b_out), .out_valid(b_valid),
    .out_ready(b_ready), .busy(b_busy), .done(b_done)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];

  typedef struct {
    logic       start;
    logic       abort;
    logic       ready;
    logic [4:0] sel;
    logic       valid;
    logic       busy;
    logic       done;
    logic [7:0] data;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic s, logic a, logic r, logic [4:0] sel,
                              logic v, logic b, logic d, logic [7:0] data);
    vec_t t;
    t.start = s; t.abort = a; t.ready = r; t.sel = sel;
    t.valid = v; t.busy = b; t.done = d; t.data = data;
    return t;
  endfunction

  function automatic logic [7:0] exp_byte(int n);
    int r = n / 5;
    case (n % 5)
      0:       return 8'(r);
      1:       return 8'h10;
      4:       return 8'(r);
      default: return 8'h00;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    b_start = v.start;
    b_abort = v.abort;
    b_ready = v.ready;
  endtask

  // Runs one dump on dut_a from a start pulse until done (or abort at byte abort_at).
  task automatic runDump(input bit toggle, input int abort_at, output int ndone);
    int  cyc = 0;
    bit  finished = 1'b0;
    bit  seen_valid = 1'b0;
    bit  prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    got.delete();
    ndone = 0;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    while (!finished && cyc < 2000) begin
      a_ready = toggle ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      if (prev_hold) begin
        checkOutput("hold_valid", 32'(a_valid), 32'd1);
        checkOutput("hold_data", 32'(a_out), 32'(prev_data));
      end
      if (a_valid && !seen_valid) begin
        seen_valid = 1'b1;
        checkOutput("first_valid_cycle", 32'(cyc), 32'd2);
      end
      if (a_done) begin
        ndone++;
        finished = 1'b1;
        checkOutput("busy_in_done_cycle", 32'(a_busy), 32'd1);
        checkOutput("bytes_at_done", 32'(got.size()), 32'd160);
      end
      if (abort_at >= 0 && a_valid && got.size() == abort_at) begin
        checkOutput("abort_point_sel", 32'(a_sel), 32'd4);
        checkOutput("abort_point_byte", 32'(a_out), 32'(exp_byte(abort_at)));
        a_abort = 1'b1;
        a_ready = 1'b1;
        finished = 1'b1;
      end else if (a_valid && a_ready) begin
        got.push_back(a_out);
      end
      prev_hold = a_valid && !a_ready;
      prev_data = a_out;
      @(negedge clk);
      cyc++;
    end
    a_abort = 1'b0;
    a_ready = 1'b1;
    if (!finished) checkOutput("dump_timeout_cycles", 32'(cyc), 32'd0);
  endtask

  task automatic checkDump(input string tag);
    checkOutput({tag, "_len"}, 32'(got.size()), 32'd160);
    for (int i = 0; i < got.size() && i < 160; i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_byte(i)));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nd;
    vecs[0]  = mk(1, 0, 0, 5'd0, 0, 0, 0, 8'h00);
    vecs[1]  = mk(1, 0, 0, 5'd7, 0, 1, 0, 8'h00);
    vecs[2]  = mk(0, 0, 0, 5'd7, 0, 1, 0, 8'h00);
    vecs[3]  = mk(0, 0, 1, 5'd7, 0, 1, 0, 8'h00);
    vecs[4]  = mk(0, 0, 1, 5'd7, 0, 1, 0, 8'h00);
    vecs[5]  = mk(0, 0, 0, 5'd7, 1, 1, 0, 8'h07);
    vecs[6]  = mk(0, 0, 1, 5'd7, 1, 1, 0, 8'h07);
    vecs[7]  = mk(0, 0, 1, 5'd7, 1, 1, 0, 8'hDE);
    vecs[8]  = mk(0, 0, 1, 5'd7, 1, 1, 0, 8'hAD);
    vecs[9]  = mk(0, 0, 0, 5'd7, 1, 1, 0, 8'hBE);
    vecs[10] = mk(0, 0, 1, 5'd7, 1, 1, 0, 8'hBE);
    vecs[11] = mk(0, 0, 1, 5'd7, 1, 1, 0, 8'hEF);
    vecs[12] = mk(1, 0, 1, 5'd0, 0, 1, 1, 8'h00);
    vecs[13] = mk(1, 0, 0, 5'd0, 0, 0, 0, 8'h00);
    vecs[14] = mk(0, 1, 0, 5'd7, 0, 1, 0, 8'h00);
    vecs[15] = mk(0, 0, 0, 5'd0, 0, 0, 0, 8'h00);
    vecs[16] = mk(0, 0, 0, 5'd0, 0, 0, 0, 8'h00);

    a_rstn = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b1;
    b_rstn = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_a", 32'({a_sel, a_out, a_valid, a_busy, a_done}), 32'd0);
    checkOutput("reset_b", 32'({b_sel, b_out, b_valid, b_busy, b_done}), 32'd0);
    a_rstn = 1'b1; b_rstn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_sel_valid_busy_done", i),
                  32'({b_sel, b_valid, b_busy, b_done}),
                  32'({vecs[i].sel, vecs[i].valid, vecs[i].busy, vecs[i].done}));
      if (vecs[i].valid)
        checkOutput($sformatf("vec%0d_data", i), 32'(b_out), 32'(vecs[i].data));
    end
    applyStimulus(mk(0, 0, 0, 5'd0, 0, 0, 0, 8'h00));

    $display("[TB] full dump, out_ready held high");
    runDump(1'b0, -1, nd);
    checkDump("full");
    checkOutput("full_done_count", 32'(nd), 32'd1);
    checkOutput("full_after_done", 32'({a_busy, a_done}), 32'd0);

    $display("[TB] full dump, out_ready pattern 1,0,0,1");
    runDump(1'b1, -1, nd);
    checkDump("bp");
    checkOutput("bp_done_count", 32'(nd), 32'd1);
    checkOutput("bp_after_done", 32'({a_busy, a_done}), 32'd0);

    $display("[TB] abort during byte 3 of register 4");
    runDump(1'b0, 22, nd);
    checkOutput("abort_next_cycle", 32'({a_sel, a_valid, a_busy, a_done}), 32'd0);
    checkOutput("abort_no_done", 32'(nd), 32'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_stays_idle", 32'({a_busy, a_done}), 32'd0);
    end
    runDump(1'b0, -1, nd);
    checkDump("replay");

    $display("[TB] reset mid-SEND");
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    repeat (8) @(negedge clk);
    for (int w = 0; w < 20 && !a_valid; w++) @(negedge clk);
    checkOutput("midsend_valid", 32'(a_valid), 32'd1);
    a_rstn = 1'b0; a_start = 1'b1;
    @(negedge clk);
    checkOutput("midreset_outputs", 32'({a_sel, a_out, a_valid, a_busy, a_done}), 32'd0);
    a_rstn = 1'b1; a_start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("start_in_reset_ignored", 32'({a_busy, a_valid, a_done}), 32'd0);
    end
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    checkOutput("start_after_reset", 32'({a_sel, a_busy}), 32'({5'd0, 1'b1}));
    a_abort = 1'b1;
    @(negedge clk); a_abort = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_scanner.md
REG_DUMP_SCANNER -- requirements
Module: reg_dump_scanner

Interface
REQ-001 Parameter FIRST_REG, default 0: first register index scanned.
REQ-002 Parameter LAST_REG, default 31: last register index scanned; FIRST_REG <= LAST_REG <= 31.
REQ-003 Parameter SETTLE_CYCLES, default 1 (range 1..15): cycles Reg_Sel is held before Reg_Data is sampled.
REQ-004 Port clk, input, 1: the single clock; all state changes on rising edge.
REQ-005 Port rstn, input, 1: reset, synchronous, active-low.
REQ-006 Port start, input, 1: one-cycle request to begin a dump; sampled only in IDLE.
REQ-007 Port abort, input, 1: terminate the dump at the next edge; no done pulse.
REQ-008 Port Reg_Sel, output, 5: register index driven to the CPU debug read port.
REQ-009 Port Reg_Data, input, 32: combinational register value for Reg_Sel.
REQ-010 Port out_data, output, 8: stream byte.
REQ-011 Port out_valid, output, 1: out_data is valid.
REQ-012 Port out_ready, input, 1: sink accepts; a byte transfers on a rising edge with out_valid and out_ready both high.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port done, output, 1: one-cycle pulse after the final byte transfers.

Function
REQ-015 FSM states: IDLE, SELECT, SEND, FINISH.
REQ-016 IDLE: Reg_Sel=0, out_valid=0; start=1 -> SELECT, Reg_Sel=FIRST_REG, settle counter=SETTLE_CYCLES.
REQ-017 SELECT: Reg_Sel held; counter decrements each cycle; in the cycle with counter==1, Reg_Data is latched into a 40-bit frame {3'b000, Reg_Sel, Reg_Data}; next state SEND.
REQ-018 Latency: start accepted at edge k -> Reg_Sel valid from k+1 -> first out_valid high in the cycle after edge k+1+SETTLE_CYCLES.
REQ-019 SEND: 5 bytes per register, MSB first: index byte, then Reg_Data[31:24], [23:16], [15:8], [7:0].
REQ-020 out_valid stays high and out_data stays stable until transfer; out_valid never drops without a transfer, except on abort or reset.
REQ-021 After a transfer, the next byte is presented in the next cycle (no bubble); out_ready held high gives one byte per cycle.
REQ-022 Transfer of byte 5 with Reg_Sel<LAST_REG: Reg_Sel increments and the FSM goes to SELECT with the counter reloaded. With Reg_Sel==LAST_REG: FSM goes to FINISH.
REQ-023 FINISH: done=1 for exactly one cycle, Reg_Sel=0, then IDLE; a new start is accepted on the first IDLE cycle.
REQ-024 start while busy is ignored; no queuing.
REQ-025 abort=1 in any non-IDLE state: next state IDLE, out_valid=0, Reg_Sel=0, done stays 0. abort has priority over a simultaneous transfer.
REQ-026 Reg_Sel never exceeds LAST_REG; the index does not wrap.
REQ-027 Total bytes per dump = 5*(LAST_REG-FIRST_REG+1); 160 at the defaults.

Reset
REQ-028 rstn=0 at a rising edge: state=IDLE, Reg_Sel=0, out_data=0, out_valid=0, busy=0, done=0, counters and frame cleared.
REQ-029 Reset mid-dump discards the partial frame; no done pulse; start is honoured only from the cycle after rstn returns high.

Structure
REQ-030 Shared package mccomp_dbg_pkg holds the state enum, BYTES_PER_REG=5 and NUM_REGS=32.
REQ-031 One sub-module, reg_dump_shifter: 40-bit load/shift-by-8 register with a byte counter and a last_byte flag; the FSM and index counter stay in reg_dump_scanner.

Verification
REQ-032 Registers $0..$31 = 32'h1000_0000+i, out_ready=1, start pulse -> 160 bytes, first five 00,10,00,00,00; last five 1F,10,00,00,1F; done pulses once; busy falls with done.
REQ-033 out_ready toggles 1,0,0,1 repeating -> out_data is stable and out_valid stays high while out_ready=0; byte sequence is identical to REQ-032.
REQ-034 FIRST_REG=7, LAST_REG=7, $7=32'hDEADBEEF -> bytes 07,DE,AD,BE,EF; Reg_Sel=7 for SETTLE_CYCLES cycles before the first valid byte.
REQ-035 abort asserted during byte 3 of register 4 -> the next cycle is IDLE with out_valid=0, Reg_Sel=0; no done; a later start replays from FIRST_REG.
REQ-036 rstn=0 for one cycle mid-SEND -> all outputs 0 in the following cycle; start on the same edge that rstn rises is ignored.
REQ-037 SETTLE_CYCLES=3, start at edge k -> first out_valid in the cycle after edge k+4; start asserted while busy has no effect.
